// File: rtl/windowed_reg_file.sv
// windowed_reg_file
//   Decode-stage register file with overlapping register windows. Each window
//   sees REGS architectural registers mapped onto a shared ring of PHYS
//   physical registers. Consecutive windows are offset by STRIDE, so the top
//   REGS-STRIDE registers of one window alias the bottom registers of the next.
//   The ring wraps around: the last window aliases window 0.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears pointer and all registers)
//   ld_wdn     load the window pointer from wnd_in at the next edge
//   wnd_in     new window number
//   cur_win    current window pointer (registered)
//   rd_addr_a  source A architectural address (read in cur_win)
//   rd_addr_b  source B architectural address (read in cur_win)
//   rd_data_a  source A operand (combinational, write-bypassed)
//   rd_data_b  source B operand (combinational, write-bypassed)
//   is_equal   rd_data_a == rd_data_b, for same-cycle branch resolution
//   wr_en      write-back enable
//   wr_win     window the write-back instruction was decoded in
//   wr_addr    write-back architectural address
//   wr_data    write-back data
module windowed_reg_file #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 2,
    parameter int unsigned WIN_AW = 2,
    parameter int unsigned STRIDE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_wdn,
    input  logic [WIN_AW-1:0] wnd_in,
    output logic [WIN_AW-1:0] cur_win,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              is_equal,
    input  logic              wr_en,
    input  logic [WIN_AW-1:0] wr_win,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned NUM_WIN = 2 ** WIN_AW;
    localparam int unsigned PHYS    = NUM_WIN * STRIDE;
    localparam int unsigned PHYS_AW = (PHYS > 1) ? $clog2(PHYS) : 1;

    // Physical index of an architectural register in a given window, modulo
    // the ring size so the last window wraps onto the first.
    function automatic logic [PHYS_AW-1:0] phys_idx(input logic [WIN_AW-1:0] win,
                                                    input logic [REG_AW-1:0] addr);
        int unsigned sum;
        sum = 32'(win) * STRIDE + 32'(addr);
        return PHYS_AW'(sum % PHYS);
    endfunction

    logic [DATA_W-1:0]  regs_q [PHYS];
    logic [DATA_W-1:0]  regs_d [PHYS];
    logic [WIN_AW-1:0]  cur_win_q, cur_win_d;

    logic [PHYS_AW-1:0] wr_idx, rd_idx_a, rd_idx_b;

    assign wr_idx   = phys_idx(wr_win, wr_addr);
    assign rd_idx_a = phys_idx(cur_win_q, rd_addr_a);
    assign rd_idx_b = phys_idx(cur_win_q, rd_addr_b);

    // Next state: reset dominates both the write port and the pointer load.
    // The write uses its own window tag, never cur_win or wnd_in.
    always_comb begin
        regs_d    = regs_q;
        cur_win_d = cur_win_q;
        if (rst) begin
            cur_win_d = '0;
            for (int i = 0; i < int'(PHYS); i++) begin
                regs_d[i] = '0;
            end
        end else begin
            if (ld_wdn) begin
                cur_win_d = wnd_in;
            end
            // An unknown wr_en falls to the no-write path.
            if (wr_en) begin
                regs_d[wr_idx] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        cur_win_q <= cur_win_d;
        for (int i = 0; i < int'(PHYS); i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Bypass compares physical indices so writes through an aliasing window
    // are forwarded too.
    always_comb begin
        rd_data_a = regs_q[rd_idx_a];
        rd_data_b = regs_q[rd_idx_b];
        if (wr_en && (wr_idx == rd_idx_a)) begin
            rd_data_a = wr_data;
        end
        if (wr_en && (wr_idx == rd_idx_b)) begin
            rd_data_b = wr_data;
        end
    end

    assign is_equal = (rd_data_a == rd_data_b);
    assign cur_win  = cur_win_q;

endmodule

// File: tb/tb_windowed_reg_file.sv
// Directed bench for windowed_reg_file with default parameters
// (phys(win,addr) = (2*win + addr) mod 8).
module tb_windowed_reg_file;

    logic        clk;
    logic        rst;
    logic        ld_wdn;
    logic [1:0]  wnd_in;
    logic [1:0]  cur_win;
    logic [1:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        is_equal;
    logic        wr_en;
    logic [1:0]  wr_win, wr_addr;
    logic [15:0] wr_data;

    int n_vec;
    int n_err;

    windowed_reg_file dut (
        .clk       (clk),
        .rst       (rst),
        .ld_wdn    (ld_wdn),
        .wnd_in    (wnd_in),
        .cur_win   (cur_win),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .is_equal  (is_equal),
        .wr_en     (wr_en),
        .wr_win    (wr_win),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [1:0]  wnd;
        logic [1:0]  ra;
        logic [1:0]  rb;
        logic        we;
        logic [1:0]  ww;
        logic [1:0]  wa;
        logic [15:0] wd;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        eeq;
        logic [1:0]  ewin;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs shortly after the falling edge.
    task automatic drive(input logic ld, input logic [1:0] wnd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic we, input logic [1:0] ww,
                         input logic [1:0] wa, input logic [15:0] wd);
        @(negedge clk);
        ld_wdn    = ld;
        wnd_in    = wnd;
        rd_addr_a = ra;
        rd_addr_b = rb;
        wr_en     = we;
        wr_win    = ww;
        wr_addr   = wa;
        wr_data   = wd;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Columns: ld wnd ra rb we ww wa wd | exp_a exp_b exp_eq exp_win
        vecs[0]  = '{1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 16'h1111, 16'h1111, 16'h1111, 1'b1, 2'd0};
        vecs[1]  = '{1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 2'd1, 2'd0, 16'h1234, 16'h1111, 16'h1234, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 2'd3, 2'd3, 16'hBEEF, 16'hBEEF, 16'h1234, 1'b0, 2'd0};
        vecs[3]  = '{1'b0, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 2'd0, 16'h0000, 16'hBEEF, 16'h1234, 1'b0, 2'd0};
        vecs[4]  = '{1'b1, 2'd2, 2'd3, 2'd0, 1'b1, 2'd2, 2'd1, 16'h2222, 16'h0000, 16'h1111, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h2222, 16'h0000, 1'b0, 2'd2};
        vecs[6]  = '{1'b1, 2'd1, 2'd1, 2'd1, 1'b1, 2'd0, 2'd3, 16'h0005, 16'h2222, 16'h2222, 1'b1, 2'd2};
        vecs[7]  = '{1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0005, 16'h1234, 1'b0, 2'd1};
        vecs[8]  = '{1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 2'd0, 2'd2, 16'h00AA, 16'h2222, 16'h00AA, 1'b0, 2'd1};
        vecs[9]  = '{1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0005, 16'h00AA, 1'b0, 2'd1};
        vecs[10] = '{1'b0, 2'd0, 2'd1, 2'd1, 1'b1, 2'd0, 2'd1, 16'h00FF, 16'h00FF, 16'h00FF, 1'b1, 2'd0};
        vecs[11] = '{1'b0, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h00FF, 16'h00AA, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 2'd3, 2'd3, 2'd0, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0005, 16'h1111, 1'b0, 2'd0};
        vecs[13] = '{1'b0, 2'd0, 2'd2, 2'd3, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h1111, 16'h00FF, 1'b0, 2'd3};
        vecs[14] = '{1'b0, 2'd0, 2'd2, 2'd0, 1'b1, 2'd3, 2'd0, 16'h1111, 16'h1111, 16'h1111, 1'b1, 2'd3};

        rst       = 1'b1;
        ld_wdn    = 1'b0;
        wnd_in    = 2'd0;
        rd_addr_a = 2'd0;
        rd_addr_b = 2'd0;
        wr_en     = 1'b0;
        wr_win    = 2'd0;
        wr_addr   = 2'd0;
        wr_data   = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        drive(1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 2'd0, 2'd0, 16'h0000);
        rst = 1'b0;
        #1;
        check("init.win", 32'(cur_win), 32'd0);
        check("init.a", 32'(rd_data_a), 32'h0);
        check("init.b", 32'(rd_data_b), 32'h0);
        check("init.eq", 32'(is_equal), 32'd1);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].ld, vecs[i].wnd, vecs[i].ra, vecs[i].rb,
                  vecs[i].we, vecs[i].ww, vecs[i].wa, vecs[i].wd);
            check($sformatf("v%0d.a", i), 32'(rd_data_a), 32'(vecs[i].ea));
            check($sformatf("v%0d.b", i), 32'(rd_data_b), 32'(vecs[i].eb));
            check($sformatf("v%0d.eq", i), 32'(is_equal), 32'(vecs[i].eeq));
            check($sformatf("v%0d.win", i), 32'(cur_win), 32'(vecs[i].ewin));
        end

        // Unknown write enable must leave state untouched (phys0 holds 0x1111).
        drive(1'b0, 2'd0, 2'd2, 2'd2, 1'bx, 2'd3, 2'd2, 16'hDEAD);
        drive(1'b0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 16'h0000);
        check("xwe.known", 32'($isunknown(rd_data_a)), 32'd0);
        check("xwe.a", 32'(rd_data_a), 32'h1111);

        // Reset dominates a concurrent write and window load.
        rst = 1'b1;
        drive(1'b1, 2'd2, 2'd0, 2'd0, 1'b1, 2'd3, 2'd2, 16'h7777);
        drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 16'h0000);
        rst = 1'b0;
        #1;
        check("rst.win", 32'(cur_win), 32'd0);
        check("rst.eq", 32'(is_equal), 32'd1);

        // Every window, every register now reads zero.
        for (int w = 0; w < 4; w++) begin
            drive(1'b1, 2'(w), 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 16'h0000);
            for (int r = 0; r < 4; r++) begin
                drive(1'b0, 2'd0, 2'(r), 2'(3 - r), 1'b0, 2'd0, 2'd0, 16'h0000);
                check($sformatf("clr.w%0d.a%0d", w, r), 32'(rd_data_a), 32'h0);
                check($sformatf("clr.w%0d.b%0d", w, 3 - r), 32'(rd_data_b), 32'h0);
            end
            check($sformatf("clr.w%0d.win", w), 32'(cur_win), 32'(w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
